core_arbiter: RTL and testbench

- Two-to-one arbiter for the core memory request/grant/rvalid protocol.
- Shares one downstream core bus slave between two core-side masters, e.g. the instruction fetch and data ports of the CPU.
- Tracks outstanding granted transactions in an ID FIFO, so in-order responses (rvalid/rdata/err) route back to the master that issued them.
- Sits between the core and the single bus bridge.

---
 rtl/core_arbiter.sv | 177 +++++++++++++++++
 tb/tb_core_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_arbiter.sv
// Two-to-one arbiter for the core req/gnt/rvalid bus: muxes two masters onto one slave
// and routes in-order responses back through a FIFO of granted master IDs.
module core_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit FIXED_PRIO      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        s_req,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_err,

    output logic        proto_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // ST_WAIT: a request is on the bus without a grant, so the selection is frozen
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lock_state_e;

    lock_state_e                state_q, state_d;
    logic                       lock_sel_q, lock_sel_d;
    logic                       last_q, last_d;
    logic                       proto_err_q, proto_err_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;

    logic full;
    logic empty;
    logic sel;
    logic sel_req;
    logic s_req_w;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

    // sel is 0 (m0) when nobody is eligible so the slave sees stable m0 fields
    always_comb begin
        sel = 1'b0;
        if (state_q == ST_WAIT) begin
            sel = lock_sel_q;
        end else if (!full) begin
            if (m0_req && m1_req) begin
                sel = FIXED_PRIO ? 1'b0 : ~last_q;
            end else begin
                sel = m1_req;
            end
        end
    end

    assign sel_req = sel ? m1_req : m0_req;
    assign s_req_w = sel_req && !full && !rst;
    assign push    = s_req_w && s_gnt;
    assign pop     = s_rvalid && !empty && !rst;
    assign head    = id_q[rptr_q];

    always_comb begin
        state_d     = state_q;
        lock_sel_d  = lock_sel_q;
        last_d      = last_q;
        proto_err_d = proto_err_q;
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        id_d        = id_q;

        if (s_req_w && !s_gnt) begin
            state_d    = ST_WAIT;
            lock_sel_d = sel;
        end else if (s_gnt) begin
            state_d = ST_IDLE;
        end

        if (push) begin
            id_d[wptr_q] = sel;
            wptr_d       = ptr_inc(wptr_q);
            last_d       = sel;
        end

        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (s_rvalid && empty) begin
            proto_err_d = 1'b1;
        end
    end

    // last winner resets to m1 so m0 wins the first contested round
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_sel_q  <= 1'b0;
            last_q      <= 1'b1;
            proto_err_q <= 1'b0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            lock_sel_q  <= lock_sel_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            id_q        <= id_d;
        end
    end

    assign s_req   = s_req_w;
    assign s_we    = sel ? m1_we    : m0_we;
    assign s_be    = sel ? m1_be    : m0_be;
    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    assign m0_gnt    = push && !sel;
    assign m1_gnt    = push && sel;
    assign m0_rvalid = pop && !head;
    assign m1_rvalid = pop && head;
    assign m0_err    = pop && !head && s_err;
    assign m1_err    = pop && head && s_err;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_core_arbiter.sv
// Bench for core_arbiter: directed protocol scenarios followed by random traffic,
// all checked against a queue-based reference model of the arbiter.
module tb_core_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_rvalid, m0_we, m0_err;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_gnt, m1_rvalid, m1_we, m1_err;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_gnt, s_rvalid, s_we, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: queue of granted master ids, pending (locked) master, last winner
    int mq[$];
    int last_w  = 1;
    int lock_m  = -1;
    bit perr    = 1'b0;
    bit g0, g1;

    core_arbiter #(.MAX_OUTSTANDING(MAXO), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_we(m0_we),
        .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_we(m1_we),
        .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_req(s_req), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_we(s_we), .s_be(s_be),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_err(s_err),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Inputs are set just after a rising edge; this checks mid-cycle, advances the model,
    // then returns 1 time unit after the next rising edge.
    task automatic cycle();
        int  es;
        int  h;
        bit  full, ereq;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea, ew;
        #3;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            chk("rst_s_req", {31'd0, s_req}, 32'd0);
            chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            chk("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
            mq.delete();
            last_w = 1;
            lock_m = -1;
            perr   = 1'b0;
            @(posedge clk);
            #1;
            return;
        end

        full = (mq.size() == MAXO);
        if (lock_m >= 0)            es = lock_m;
        else if (full)              es = -1;
        else if (m0_req && m1_req)  es = (last_w == 1) ? 0 : 1;
        else if (m0_req)            es = 0;
        else if (m1_req)            es = 1;
        else                        es = -1;
        ereq = (es == 0) ? m0_req : (es == 1) ? m1_req : 1'b0;
        ereq = ereq && !full;
        g0 = ereq && s_gnt && (es == 0);
        g1 = ereq && s_gnt && (es == 1);
        h  = (s_rvalid && mq.size() > 0) ? mq[0] : -1;

        ewe = (es == 1) ? m1_we    : m0_we;
        ebe = (es == 1) ? m1_be    : m0_be;
        ea  = (es == 1) ? m1_addr  : m0_addr;
        ew  = (es == 1) ? m1_wdata : m0_wdata;

        chk("s_req", {31'd0, s_req}, {31'd0, ereq});
        chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, g1, g0});
        chk("s_addr", s_addr, ea);
        chk("s_wdata", s_wdata, ew);
        chk("s_we_be", {27'd0, s_we, s_be}, {27'd0, ewe, ebe});
        chk("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, h == 1, h == 0});
        chk("err", {30'd0, m1_err, m0_err}, {30'd0, h == 1 && s_err, h == 0 && s_err});
        if (h >= 0) begin
            chk("rdata", (h == 1) ? m1_rdata : m0_rdata, s_rdata);
        end
        chk("proto_err", {31'd0, proto_err}, {31'd0, perr});

        if (h >= 0)                mq.pop_front();
        else if (s_rvalid)         perr = 1'b1;
        if (g0 || g1) begin
            mq.push_back(es);
            last_w = es;
        end
        if (ereq && !s_gnt)        lock_m = es;
        else if (s_gnt)            lock_m = -1;

        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_be = 4'hf; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 4'hf; m1_addr = 0; m1_wdata = 0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 0; s_err = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        // single m0 read: zero-cycle grant, response next cycle
        m0_req = 1; m0_addr = 32'h0000_1000; s_gnt = 1;
        cycle();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        cycle();
        s_rvalid = 0;

        // both masters requesting every cycle with s_gnt=1: grants alternate
        for (int i = 0; i < 6; i++) begin
            m0_req = 1; m0_addr = 32'h100 + i; m0_wdata = $urandom;
            m1_req = 1; m1_addr = 32'h200 + i; m1_wdata = $urandom;
            s_gnt = 1; s_rvalid = (i > 0); s_rdata = $urandom;
            cycle();
        end
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = $urandom;
        cycle();
        s_rvalid = 0;

        // m1 waits three cycles; m0 arrives meanwhile but must not disturb the bus
        m1_req = 1; m1_addr = 32'hA000_0004; m1_wdata = 32'h1234_5678;
        cycle();
        m0_req = 1; m0_addr = 32'hB000_0008;
        cycle();
        cycle();
        s_gnt = 1;
        cycle();
        m1_req = 0;
        cycle();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h0000_0011;
        cycle();
        s_rdata = 32'h0000_0022;
        cycle();
        s_rvalid = 0;

        // fill the FIFO, then check the one-cycle bubble after a pop
        m0_req = 1; m0_addr = 32'hC000_0000; s_gnt = 1;
        cycle();
        m0_addr = 32'hC000_0004;
        cycle();
        m0_addr = 32'hC000_0008;
        cycle();
        s_rvalid = 1; s_rdata = 32'h5555_AAAA;
        cycle();
        s_rvalid = 0;
        cycle();
        m0_req = 0; s_gnt = 0; s_rvalid = 1;
        cycle();
        cycle();
        s_rvalid = 0;

        // m1 write returning an error
        m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h0000_2000;
        m1_wdata = 32'hCAFE_F00D; s_gnt = 1;
        cycle();
        m1_req = 0; m1_we = 0; s_gnt = 0; s_rvalid = 1; s_err = 1;
        cycle();
        s_rvalid = 0; s_err = 0;

        // stray response sets the sticky flag; reset clears it
        s_rvalid = 1;
        cycle();
        s_rvalid = 0;
        cycle();
        cycle();
        m0_req = 1; m0_addr = 32'h0000_3000;
        rst = 1'b1;
        cycle();
        rst = 1'b0; m0_req = 0;
        cycle();

        // random traffic; masters hold requests until granted
        idle_inputs();
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) begin
                idle_inputs();
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            if (!m0_req && $urandom_range(0, 2) != 0) begin
                m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_be = 4'($urandom);
                m0_addr = $urandom; m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) != 0) begin
                m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_be = 4'($urandom);
                m1_addr = $urandom; m1_wdata = $urandom;
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            s_err    = ($urandom_range(0, 7) == 0);
            cycle();
            if (g0) m0_req = 0;
            if (g1) m1_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
